popcount_window_sum: RTL and testbench

Downstream consumer of the 8-bit ones-counter stage. It accepts that stage's 4-bit count (0..8) with a valid strobe and keeps a sliding-window sum of the last DEPTH accepted counts. It also produces a window average and a threshold alarm. It sits between the ones-counter and the result logger/console writer, turning per-sample counts into a smoothed density figure.

---
 rtl/popcount_window_sum_pkg.sv | 14 +
 rtl/popcount_window_sum_ring.sv | 48 ++++
 rtl/popcount_window_sum.sv | 96 +++++++++
 tb/tb_popcount_window_sum.sv | 136 +++++++++++++
 4 files changed

// File: rtl/popcount_window_sum_pkg.sv
// popcount_window_sum_pkg: shared widths, limits and clamp helper for the ones-count pipeline.
//   COUNT_W     width of a per-sample ones count
//   MAX_COUNT   largest legal count (an 8-bit word has at most 8 ones)
//   clamp_count saturates an out-of-range count to MAX_COUNT
package popcount_window_sum_pkg;

  localparam int COUNT_W = 4;
  localparam logic [COUNT_W-1:0] MAX_COUNT = 4'd8;

  function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] c);
    return (c > MAX_COUNT) ? MAX_COUNT : c;
  endfunction

endpackage

// File: rtl/popcount_window_sum_ring.sv
// window_ring: DEPTH x COUNT_W circular buffer exposing the entry about to be overwritten.
//   clk     rising-edge clock
//   rst     asynchronous active-high reset, zeroes buffer and pointer
//   flush   synchronous zeroing of buffer and pointer, wins over we
//   we      write wdata at wr_ptr and advance the pointer
//   wdata   count to store
//   oldest  combinational view of mem[wr_ptr], the sample leaving the window
//   wr_ptr  current write position
module window_ring
  import popcount_window_sum_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               we,
  input  logic [COUNT_W-1:0] wdata,
  output logic [COUNT_W-1:0] oldest,
  output logic [PTR_W-1:0]   wr_ptr
);

  logic [COUNT_W-1:0] mem_q [DEPTH];
  logic [COUNT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   ptr_q, ptr_d;

  // DEPTH is a power of two, so the pointer wraps naturally.
  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      mem_d[i] = flush ? '0 : (we && ptr_q == PTR_W'(i)) ? wdata : mem_q[i];
    ptr_d = flush ? '0 : we ? ptr_q + 1'b1 : ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      ptr_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      ptr_q <= ptr_d;
    end
  end

  assign oldest = mem_q[ptr_q];
  assign wr_ptr = ptr_q;

endmodule

// File: rtl/popcount_window_sum.sv
// popcount_window_sum: sliding-window sum, average and threshold alarm over the last DEPTH ones counts.
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   clear      synchronous flush of the window, dominates in_valid
//   in_valid   in_count presented this cycle (no backpressure)
//   in_count   ones count 0..8; larger values are clamped to 8 and flagged
//   out_valid  one-cycle pulse: window full and outputs reflect a new sample
//   out_sum    sum of the last min(fill, DEPTH) accepted counts
//   out_avg    out_sum >> log2(DEPTH)
//   out_alarm  out_sum >= THRESH
//   err_range  sticky: an accepted in_count exceeded 8
module popcount_window_sum
  import popcount_window_sum_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int THRESH = 16,
  parameter int SUM_W  = 4 + $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [COUNT_W-1:0] in_count,
  output logic               out_valid,
  output logic [SUM_W-1:0]   out_sum,
  output logic [3:0]         out_avg,
  output logic               out_alarm,
  output logic               err_range
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int FILL_W = PTR_W + 1;
  localparam logic [FILL_W-1:0] FULL      = FILL_W'(DEPTH);
  localparam logic [FILL_W-1:0] LAST_FILL = FILL_W'(DEPTH - 1);
  localparam logic [SUM_W-1:0]  THRESH_V  = SUM_W'(THRESH);

  logic               accept;
  logic [COUNT_W-1:0] v;
  logic [COUNT_W-1:0] oldest;
  logic [PTR_W-1:0]   wr_ptr;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic               valid_q, valid_d;
  logic [3:0]         avg_q, avg_d;
  logic               alarm_q, alarm_d;
  logic               err_q, err_d;

  assign accept = in_valid && !clear;
  assign v      = clamp_count(in_count);

  window_ring #(.DEPTH(DEPTH)) u_ring (
    .clk    (clk),
    .rst    (rst),
    .flush  (clear),
    .we     (accept),
    .wdata  (v),
    .oldest (oldest),
    .wr_ptr (wr_ptr)
  );

  // The oldest entry is still zero while filling, so one update rule covers both phases.
  // Modular SUM_W arithmetic is exact because the true sum never exceeds 8*DEPTH.
  always_comb begin
    sum_d   = clear ? '0 : accept ? sum_q + SUM_W'(v) - SUM_W'(oldest) : sum_q;
    fill_d  = clear ? '0 : (accept && fill_q != FULL) ? fill_q + 1'b1 : fill_q;
    valid_d = accept && fill_q >= LAST_FILL;
    avg_d   = 4'(sum_d >> PTR_W);
    alarm_d = sum_d >= THRESH_V;
    err_d   = clear ? 1'b0 : (accept && in_count > MAX_COUNT) ? 1'b1 : err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q  <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      avg_q   <= '0;
      alarm_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      fill_q  <= fill_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      avg_q   <= avg_d;
      alarm_q <= alarm_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_avg   = avg_q;
  assign out_alarm = alarm_q;
  assign err_range = err_q;

endmodule

// File: tb/tb_popcount_window_sum.sv
// tb_popcount_window_sum: directed self-checking bench for popcount_window_sum (DEPTH=4, THRESH=16).
module tb_popcount_window_sum;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_count = '0;
  logic       out_valid;
  logic [5:0] out_sum;
  logic [3:0] out_avg;
  logic       out_alarm;
  logic       err_range;

  int tests = 0;
  int fails = 0;

  popcount_window_sum #(.DEPTH(4), .THRESH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_avg   (out_avg),
    .out_alarm (out_alarm),
    .err_range (err_range)
  );

  always #5 clk = ~clk;

  // Present inputs for one edge, then leave the bench 1 time unit after that edge.
  task automatic step(input logic v, input logic [3:0] c, input logic cl);
    in_valid = v;
    in_count = c;
    clear    = cl;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic test_reset();
    step(1, 4'd9, 0);
    step(1, 4'd8, 0);
    tests++; if (out_sum !== 6'd16) begin fails++; $display("FAIL pre_reset_sum got %0d want 16", out_sum); end
    tests++; if (err_range !== 1'b1) begin fails++; $display("FAIL pre_reset_err got %b want 1", err_range); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({out_valid, out_sum, out_avg, out_alarm, err_range} !== '0) begin fails++; $display("FAIL async_reset got v=%b s=%0d a=%0d al=%b e=%b want all 0", out_valid, out_sum, out_avg, out_alarm, err_range); end
    for (int i = 0; i < 3; i++) begin
      step(1, 4'd5, 0);
      tests++; if ({out_valid, out_sum, out_avg, out_alarm, err_range} !== '0) begin fails++; $display("FAIL reset_hold%0d got v=%b s=%0d want all 0", i, out_valid, out_sum); end
    end
    #3 rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [3:0] cnt [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
    logic [5:0] exp [4] = '{6'd1, 6'd3, 6'd6, 6'd10};
    for (int i = 0; i < 4; i++) begin
      step(1, cnt[i], 0);
      tests++; if (out_sum !== exp[i]) begin fails++; $display("FAIL fill_sum%0d got %0d want %0d", i, out_sum, exp[i]); end
      tests++; if (out_valid !== (i == 3)) begin fails++; $display("FAIL fill_valid%0d got %b want %b", i, out_valid, i == 3); end
    end
    tests++; if (out_avg !== 4'd2) begin fails++; $display("FAIL fill_avg got %0d want 2", out_avg); end
    tests++; if (out_alarm !== 1'b0) begin fails++; $display("FAIL fill_alarm got %b want 0", out_alarm); end
  endtask

  task automatic test_slide();
    logic [3:0] cnt [4] = '{4'd8, 4'd0, 4'd0, 4'd0};
    logic [5:0] sum [4] = '{6'd17, 6'd15, 6'd12, 6'd8};
    logic [3:0] avg [4] = '{4'd4, 4'd3, 4'd3, 4'd2};
    logic       alm [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step(1, cnt[i], 0);
      tests++; if (out_sum !== sum[i]) begin fails++; $display("FAIL slide_sum%0d got %0d want %0d", i, out_sum, sum[i]); end
      tests++; if (out_avg !== avg[i]) begin fails++; $display("FAIL slide_avg%0d got %0d want %0d", i, out_avg, avg[i]); end
      tests++; if (out_alarm !== alm[i]) begin fails++; $display("FAIL slide_alarm%0d got %b want %b", i, out_alarm, alm[i]); end
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL slide_valid%0d got %b want 1", i, out_valid); end
    end
  endtask

  task automatic test_gaps();
    logic [5:0] sum [4] = '{6'd5, 6'd10, 6'd15, 6'd20};
    for (int i = 0; i < 4; i++) begin
      step(1, 4'd5, 0);
      tests++; if (out_valid !== 1'b1 || out_sum !== sum[i]) begin fails++; $display("FAIL gap_accept%0d got v=%b s=%0d want v=1 s=%0d", i, out_valid, out_sum, sum[i]); end
      step(0, 4'd7, 0);
      tests++; if (out_valid !== 1'b0 || out_sum !== sum[i]) begin fails++; $display("FAIL gap_idle%0d got v=%b s=%0d want v=0 s=%0d", i, out_valid, out_sum, sum[i]); end
    end
    tests++; if (out_avg !== 4'd5 || out_alarm !== 1'b1) begin fails++; $display("FAIL gap_final got avg=%0d al=%b want avg=5 al=1", out_avg, out_alarm); end
  endtask

  task automatic test_range();
    logic [3:0] cnt [3] = '{4'd1, 4'd2, 4'd3};
    logic [5:0] sum [3] = '{6'd9, 6'd11, 6'd14};
    step(0, 4'd0, 1);
    tests++; if (out_sum !== 6'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL range_clear got s=%0d v=%b want s=0 v=0", out_sum, out_valid); end
    step(1, 4'd12, 0);
    tests++; if (out_sum !== 6'd8 || err_range !== 1'b1 || out_valid !== 1'b0) begin fails++; $display("FAIL range_clamp got s=%0d e=%b v=%b want s=8 e=1 v=0", out_sum, err_range, out_valid); end
    for (int i = 0; i < 3; i++) begin
      step(1, cnt[i], 0);
      tests++; if (out_sum !== sum[i] || err_range !== 1'b1) begin fails++; $display("FAIL range_sticky%0d got s=%0d e=%b want s=%0d e=1", i, out_sum, err_range, sum[i]); end
    end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL range_valid got %b want 1", out_valid); end
  endtask

  task automatic test_clear_collision();
    logic [3:0] cnt [4] = '{4'd7, 4'd7, 4'd7, 4'd9};
    logic [5:0] sum [4] = '{6'd2, 6'd4, 6'd6, 6'd8};
    step(0, 4'd0, 1);
    for (int i = 0; i < 4; i++) step(1, cnt[i], 0);
    tests++; if (out_sum !== 6'd29 || out_valid !== 1'b1 || err_range !== 1'b1) begin fails++; $display("FAIL coll_full got s=%0d v=%b e=%b want s=29 v=1 e=1", out_sum, out_valid, err_range); end
    step(1, 4'd7, 1);
    tests++; if ({out_valid, out_sum, out_avg, out_alarm, err_range} !== '0) begin fails++; $display("FAIL coll_clear got v=%b s=%0d a=%0d al=%b e=%b want all 0", out_valid, out_sum, out_avg, out_alarm, err_range); end
    for (int i = 0; i < 4; i++) begin
      step(1, 4'd2, 0);
      tests++; if (out_sum !== sum[i] || out_valid !== (i == 3)) begin fails++; $display("FAIL coll_refill%0d got s=%0d v=%b want s=%0d v=%b", i, out_sum, out_valid, sum[i], i == 3); end
    end
  endtask

  initial begin
    #12 rst = 1'b0;
    test_reset();
    test_fill();
    test_slide();
    test_gaps();
    test_range();
    test_clear_collision();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
